// File: rtl/bram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter_if
//   Requester-side bus of the block RAM port arbiter. Bundles every
//   requester's request channel (valid/ready plus address, write data and
//   byte strobes, packed with slice i belonging to requester i) and the
//   shared response channel (one-hot valid pulse plus common read data).
//
//   Modports:
//     master - requester side: drives requests, sinks grants and responses
//     slave  - arbiter side:   sinks requests, drives grants and responses
// -----------------------------------------------------------------------------
interface bram_port_arbiter_if #(
  parameter int NREQ      = 3,
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int ADDR_W    = 10
) ();
  localparam int DATA_W = NB_COL * COL_WIDTH;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ*NB_COL-1:0] req_wstrb;
  logic [NREQ-1:0]        resp_valid;
  logic [DATA_W-1:0]      resp_rdata;

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//   Shares one port of a single-clock, read-first, byte-write block RAM among
//   NREQ requesters. A combinational round-robin arbiter grants at most one
//   request per cycle and drives the RAM pins directly from the winner. A tag
//   pipeline as deep as the RAM read latency carries {valid, requester index}
//   so that every accepted request (read or write) yields exactly one
//   response pulse to its originator; write responses carry the word's prior
//   contents because the RAM is read-first.
//
//   Ports:
//     clk        single clock, shared with the RAM port
//     rst        synchronous active-high reset
//     req_bus    requester bus (slave modport): valid/ready, addr, wdata,
//                wstrb (all-zero = read), one-hot resp_valid, resp_rdata
//     ram_addr   RAM port address
//     ram_din    RAM port write data
//     ram_we     RAM port byte write enables
//     ram_en     RAM port enable
//     ram_regce  RAM output register clock enable (0 when LATENCY = 1)
//     ram_rst    RAM output reset, follows rst
//     ram_dout   RAM port read data, returned untouched as resp_rdata
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter  int NREQ      = 3,
  parameter  int NB_COL    = 4,
  parameter  int COL_WIDTH = 8,
  parameter  int ADDR_W    = 10,
  parameter  int LATENCY   = 2,
  localparam int DATA_W    = NB_COL * COL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  bram_port_arbiter_if.slave     req_bus,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_din,
  output logic [NB_COL-1:0]      ram_we,
  output logic                   ram_en,
  output logic                   ram_regce,
  output logic                   ram_rst,
  input  logic [DATA_W-1:0]      ram_dout
);

  localparam int IDX_W = $clog2(NREQ);

  // Round-robin pointer: index of the requester with highest priority.
  logic [IDX_W-1:0]  ptr;

  // Arbitration result
  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              found;
  int                cand;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [NB_COL-1:0] sel_wstrb;

  // Tag pipeline, stage LATENCY-1 lines up with valid RAM output data.
  logic [LATENCY-1:0] tag_v;
  logic [IDX_W-1:0]   tag_idx [LATENCY];

  logic [NREQ-1:0]    resp_valid_d;

  // ---------------------------------------------------------------------------
  // Arbiter: scan ptr, ptr+1, ... (mod NREQ); the first valid requester wins.
  // The mod keeps the scan correct for non-power-of-two NREQ.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the loop; any path that
    // skips an assignment would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && req_bus.req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        sel_addr    = req_bus.req_addr[cand*ADDR_W +: ADDR_W];
        sel_wdata   = req_bus.req_wdata[cand*DATA_W +: DATA_W];
        sel_wstrb   = req_bus.req_wstrb[cand*NB_COL +: NB_COL];
      end
    end
  end

  // Grants are never held back by the response side: requesters always sink
  // resp_valid, so ready is simply the one-hot grant.
  assign req_bus.req_ready = grant;

  // RAM drive. The port is disabled during reset so nothing is read or
  // written while the tag pipeline is refusing to record accepts.
  assign ram_en   = found & ~rst;
  assign ram_we   = rst ? '0 : sel_wstrb;
  assign ram_addr = sel_addr;
  assign ram_din  = sel_wdata;
  assign ram_rst  = rst;

  // ---------------------------------------------------------------------------
  // Pointer: moves to the requester after the winner; holds when idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= IDX_W'((int'(grant_idx) + 1) % NREQ);
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: only the valid bits are reset; the index payload is don't-care
    // while its valid bit is clear, so it needs no reset path.
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= found;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v[k] <= tag_v[k-1];
      end
    end
    tag_idx[0] <= grant_idx;
    for (int k = 1; k < LATENCY; k++) begin
      tag_idx[k] <= tag_idx[k-1];
    end
  end

  // The output register captures the RAM latch one cycle after the access,
  // which is exactly when stage 0 holds that access's tag.
  assign ram_regce = (LATENCY >= 2) ? tag_v[0] : 1'b0;

  // ---------------------------------------------------------------------------
  // Response: decode the final tag. Gated by rst so a response that would
  // fall in the reset cycle is dropped along with the rest of the in-flight
  // tags. Index values >= NREQ decode to nothing.
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_valid_d = '0;
    if (!rst && tag_v[LATENCY-1]) begin
      for (int i = 0; i < NREQ; i++) begin
        if (int'(tag_idx[LATENCY-1]) == i) resp_valid_d[i] = 1'b1;
      end
    end
  end

  assign req_bus.resp_valid = resp_valid_d;
  assign req_bus.resp_rdata = ram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//   Self-checking bench for bram_port_arbiter. A behavioural read-first,
//   byte-write RAM hangs off the DUT's RAM pins. An independent reference
//   model (round-robin rule, shadow memory, queue of due responses) predicts
//   grants, RAM drive and responses every cycle. Directed scenarios are
//   followed by randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int NREQ      = 3;
  localparam int NB_COL    = 4;
  localparam int COL_WIDTH = 8;
  localparam int ADDR_W    = 10;
  localparam int LATENCY   = 2;
  localparam int DATA_W    = NB_COL * COL_WIDTH;
  localparam int DEPTH     = 1 << ADDR_W;

  typedef struct {
    int                due;
    int                idx;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [NB_COL-1:0] ram_we;
  logic              ram_en;
  logic              ram_regce;
  logic              ram_rst;
  logic [DATA_W-1:0] ram_dout;

  bram_port_arbiter_if #(
    .NREQ(NREQ), .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .ADDR_W(ADDR_W)
  ) bus ();

  bram_port_arbiter #(
    .NREQ(NREQ), .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH),
    .ADDR_W(ADDR_W), .LATENCY(LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_bus   (bus),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_en    (ram_en),
    .ram_regce (ram_regce),
    .ram_rst   (ram_rst),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i == 3) return 32'hAABBCCDD;
    if (i == 5) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural block RAM port (read-first, byte write, LATENCY 1 or 2)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ram_mem [DEPTH];
  logic              ram_loaded = 1'b0;
  logic [DATA_W-1:0] ram_latch  = '0;
  logic [DATA_W-1:0] ram_oreg   = '0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (ram_en) begin
      ram_latch <= ram_mem[ram_addr];
      for (int b = 0; b < NB_COL; b++)
        if (ram_we[b])
          ram_mem[ram_addr][b*COL_WIDTH +: COL_WIDTH] <= ram_din[b*COL_WIDTH +: COL_WIDTH];
    end
    if (LATENCY == 1 && ram_rst) ram_latch <= '0;
    if (ram_rst)        ram_oreg <= '0;
    else if (ram_regce) ram_oreg <= ram_latch;
  end

  assign ram_dout = (LATENCY == 1) ? ram_latch : ram_oreg;

  // ---------------------------------------------------------------------------
  // Reference model state and bookkeeping
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  resp_t             pend [$];
  int                m_ptr = 0;
  int                cyc   = 0;
  int                vectors     = 0;
  int                miscompares = 0;
  int                resp_seen   = 0;
  int                mark;
  logic [NREQ-1:0]   last_ready;
  logic [NREQ-1:0]   last_rv;
  logic [DATA_W-1:0] last_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [NB_COL-1:0] s);
    bus.req_valid[i]                     = v;
    bus.req_addr[i*ADDR_W +: ADDR_W]     = a;
    bus.req_wdata[i*DATA_W +: DATA_W]    = d;
    bus.req_wstrb[i*NB_COL +: NB_COL]    = s;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
  endtask

  // One clock cycle: inputs are already driven (just after the previous
  // edge). Sample mid-cycle, compare to the model, then let the edge happen
  // and advance the model by the same rules.
  task automatic run_cycle();
    int                gi;
    int                c;
    logic [NREQ-1:0]   eg;
    logic [ADDR_W-1:0] ga;
    logic [DATA_W-1:0] gd;
    logic [NB_COL-1:0] gs;
    logic [NREQ-1:0]   exp_rv;
    logic [DATA_W-1:0] exp_rd;
    logic [DATA_W-1:0] old;
    bit                have;
    #3;
    gi = -1;
    eg = '0;
    ga = '0;
    gd = '0;
    gs = '0;
    for (int k = 0; k < NREQ; k++) begin
      c = (m_ptr + k) % NREQ;
      if (gi < 0 && bus.req_valid[c]) gi = c;
    end
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ga = bus.req_addr[gi*ADDR_W +: ADDR_W];
      gd = bus.req_wdata[gi*DATA_W +: DATA_W];
      gs = bus.req_wstrb[gi*NB_COL +: NB_COL];
    end
    check("req_ready", bus.req_ready, eg);
    check("ram_en", ram_en, (gi >= 0) && !rst);
    if (!rst) begin
      check("ram_addr", ram_addr, ga);
      check("ram_din", ram_din, gd);
      check("ram_we", ram_we, gs);
    end

    have   = 1'b0;
    exp_rv = '0;
    exp_rd = '0;
    if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
      have = 1'b1;
      exp_rv[pend[0].idx] = 1'b1;
      exp_rd = pend[0].data;
    end
    check("resp_valid", bus.resp_valid, exp_rv);
    if (have) check("resp_rdata", bus.resp_rdata, exp_rd);

    last_ready = bus.req_ready;
    last_rv    = bus.resp_valid;
    last_rd    = bus.resp_rdata;
    if (|bus.resp_valid) resp_seen++;

    @(posedge clk);
    if (rst) begin
      pend.delete();
      m_ptr = 0;
    end else begin
      if (have) void'(pend.pop_front());
      if (gi >= 0) begin
        old = ref_mem[ga];
        for (int b = 0; b < NB_COL; b++)
          if (gs[b]) ref_mem[ga][b*COL_WIDTH +: COL_WIDTH] = gd[b*COL_WIDTH +: COL_WIDTH];
        pend.push_back('{due: cyc + LATENCY, idx: gi, data: old});
        m_ptr = (gi + 1) % NREQ;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    clear_reqs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_cycles(2);
    rst = 1'b0;

    // Fairness: everyone requests continuously from reset.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ADDR_W'(10 + i), '0, '0);
    mark = resp_seen;
    for (int k = 0; k < 3 * NREQ; k++) begin
      run_cycle();
      check("fair_grant", last_ready, NREQ'(1) << (k % NREQ));
    end
    clear_reqs();
    run_cycles(LATENCY + 1);
    check("fair_resp_count", resp_seen - mark, 3 * NREQ);

    // Single read of the preloaded word.
    set_req(1, 1'b1, ADDR_W'(5), '0, '0);
    run_cycle();
    clear_reqs();
    run_cycles(LATENCY);
    check("single_read_valid", last_rv, 3'b010);
    check("single_read_data", last_rd, 32'hDEADBEEF);

    // Byte write followed immediately by a read of the same word.
    set_req(0, 1'b1, ADDR_W'(3), 32'h11223344, 4'b0101);
    run_cycle();
    set_req(0, 1'b1, ADDR_W'(3), '0, '0);
    run_cycle();
    clear_reqs();
    run_cycles(LATENCY - 1);
    check("write_resp_data", last_rd, 32'hAABBCCDD);
    run_cycle();
    check("read_after_write", last_rd, 32'hAA22CC44);
    run_cycles(LATENCY);

    // Pointer skip: park the pointer at 1, then requesters 0 and 2 compete.
    set_req(0, 1'b1, ADDR_W'(7), '0, '0);
    run_cycle();
    set_req(2, 1'b1, ADDR_W'(8), '0, '0);
    run_cycle();
    check("skip_first", last_ready, 3'b100);
    set_req(2, 1'b0, '0, '0, '0);
    run_cycle();
    check("skip_second", last_ready, 3'b001);
    clear_reqs();
    run_cycles(LATENCY + 1);

    // Reset while three reads are in flight.
    mark = resp_seen;
    set_req(0, 1'b1, ADDR_W'(20), '0, '0);
    run_cycle();
    set_req(0, 1'b1, ADDR_W'(21), '0, '0);
    run_cycle();
    set_req(0, 1'b1, ADDR_W'(22), '0, '0);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    clear_reqs();
    set_req(1, 1'b1, ADDR_W'(23), '0, '0);
    set_req(2, 1'b1, ADDR_W'(24), '0, '0);
    run_cycle();
    check("post_reset_grant", last_ready, 3'b010);
    clear_reqs();
    run_cycles(LATENCY + 1);
    check("reset_drops_resp", resp_seen - mark, 1);

    // Idle: nothing requested; pointer (now 2) must hold.
    mark = resp_seen;
    run_cycles(10);
    check("idle_resp_count", resp_seen - mark, 0);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ADDR_W'(30 + i), '0, '0);
    run_cycle();
    check("idle_ptr_held", last_ready, 3'b100);
    clear_reqs();
    run_cycles(LATENCY + 1);

    // Randomized traffic over a small address window, rare resets.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
                DATA_W'($urandom),
                ($urandom_range(0, 1) == 0) ? '0 : NB_COL'($urandom));
      end
      rst = ($urandom_range(0, 49) == 0);
      run_cycle();
    end
    rst = 1'b0;
    clear_reqs();
    run_cycles(LATENCY + 1);
    check("drain_empty", pend.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one port of the team's single-clock, read-first, byte-write true dual-port block RAM among NREQ requesters (e.g. instruction fetch, load/store unit, debug/DMA). It accepts one request per cycle via valid/ready and drives the RAM port's address, data, byte-enable, enable and output-register-enable pins. It tracks the RAM's configurable read latency through a tag pipeline and returns exactly one response to the originating requester per accepted request.

## Interface
- NREQ, 3: number of requesters (2..8).
- NB_COL, 4: byte lanes per word.
- COL_WIDTH, 8: bits per lane; DATA_W = NB_COL*COL_WIDTH.
- ADDR_W, 10: word address width.
- LATENCY, 2: RAM read latency; 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE (output register).
- clk  in  1  single clock; RAM port is clocked by the same clk.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant; handshake when valid&ready at a rising edge.
- req_addr  in  NREQ*ADDR_W  packed; slice i = requester i.
- req_wdata  in  NREQ*DATA_W  packed write data.
- req_wstrb  in  NREQ*NB_COL  packed byte write enables; all-zero = read.
- resp_valid  out  NREQ  one-hot, single-cycle response pulse.
- resp_rdata  out  DATA_W  shared response data, valid where any resp_valid bit is set.
- ram_addr  out  ADDR_W  to RAM port address.
- ram_din  out  DATA_W  to RAM port input data.
- ram_we  out  NB_COL  to RAM port byte write enables.
- ram_en  out  1  to RAM port enable.
- ram_regce  out  1  to RAM port output register enable (unused when LATENCY=1).
- ram_rst  out  1  to RAM port output reset; equals rst.
- ram_dout  in  DATA_W  from RAM port output data.

## Operation
- Arbitration: combinational round-robin. Pointer ptr (log2 NREQ bits) names highest-priority requester; search ptr, ptr+1, ... mod NREQ; first valid requester wins.
- req_ready = one-hot grant, independent of response side (responses have no backpressure; requesters must always sink resp_valid).
- On grant to i: ptr <= (i+1) mod NREQ at next edge. No grant: ptr unchanged.
- RAM drive (combinational from grant): ram_en = |grant; ram_addr/ram_din/ram_we = granted requester's slices; all zero when no grant.
- Every accepted request, read or write, produces one response. Writes return prior contents (read-first RAM); readers with wstrb=0 return current contents.
- Tag pipeline: LATENCY stages, each {valid, requester index}. Stage 0 loaded at accept edge with {|grant, index}; stage k loads from k-1.
- ram_regce = stage-0 valid when LATENCY=2; constant 0 when LATENCY=1.
- resp_valid = one-hot decode of final-stage tag when valid, else 0. resp_rdata = ram_dout (pass-through, no extra register).
- Back-to-back accepts every cycle sustain full throughput; no bubbles inserted.

## Timing
- Reset values: ptr=0 (requester 0 first), all tag stages invalid, resp_valid=0, req_ready follows req_valid combinationally (ready during reset is ignored by the tag pipeline: no accept is recorded while rst=1), ram_en=0 while rst=1, ram_rst=1.
- Accept at edge T (valid&ready sampled) -> resp_valid pulse during cycle T+LATENCY (i.e. sampled at edge T+LATENCY).
- Write at edge T then read of same address accepted at edge T+1 -> read returns new data (RAM updated at edge T).
- Same-cycle requests from all NREQ: granted in round-robin order, one per cycle; each requester waits at most NREQ-1 cycles.
- Requester deasserting valid before grant: permitted; no request recorded.
- Reset mid-operation: all in-flight tags cleared; no resp_valid for requests accepted before rst; RAM output register cleared via ram_rst; RAM contents unaffected.
- Width rules: ptr wrap uses explicit mod NREQ for non-power-of-two NREQ; index decode ignores values >= NREQ (cannot occur).

## Test plan
- Single read: RAM preloaded word 5 = 0xDEADBEEF; requester 1 reads addr 5 at edge T, LATENCY=2 -> resp_valid=3'b010 at T+2, resp_rdata=0xDEADBEEF; LATENCY=1 -> same at T+1.
- Byte write then read: req 0 writes addr 3, wdata 0x11223344, wstrb 4'b0101 over 0xAABBCCDD -> write response returns 0xAABBCCDD; next-cycle read of addr 3 returns 0xAA22CC44.
- Fairness: all three requesters hold valid continuously from reset -> grants 0,1,2,0,1,2...; responses arrive in the same order at LATENCY offset, one per cycle, no gaps.
- Pointer skip: ptr=1, only requesters 0 and 2 valid -> grant 2, then 0; ptr becomes 0 then 1.
- Reset mid-flight: accept three reads on consecutive edges, assert rst for one cycle on the edge after the second accept -> no resp_valid for any of them, ptr=0, first post-reset grant to lowest-index valid requester.
- Idle: no req_valid for 10 cycles -> ram_en=0, ram_we=0, resp_valid=0, ptr unchanged.
